udma_uart_tx_fetch_ctrl: RTL and testbench

Sequences the UART transmit datapath. It fetches bytes from a uDMA linear TX channel using the req/gnt request phase and the valid/ready response phase, and buffers them in a small FIFO. It presents the bytes one at a time to the UART bit serializer over a valid/ready handshake. It sits between the uDMA TX channel and the serializer, inside the UART top-level.

---
 rtl/udma_uart_tx_fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_udma_uart_tx_fetch_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_uart_tx_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : udma_uart_tx_fetch_ctrl
// Brief    : Fetches bytes from a uDMA linear TX channel (req/gnt request
//            phase, valid/ready response phase) into a small byte FIFO and
//            presents them one at a time to the UART bit serializer.
// Revision : 1.0 - initial release
// ============================================================================
module udma_uart_tx_fetch_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                             sys_clk_i,
    input  logic                             rstn_i,
    input  logic                             cfg_en_i,
    input  logic                             cfg_clr_i,
    output logic                             data_tx_req_o,
    input  logic                             data_tx_gnt_i,
    output logic [1:0]                       data_tx_datasize_o,
    input  logic [31:0]                      data_tx_i,
    input  logic                             data_tx_valid_i,
    output logic                             data_tx_ready_o,
    output logic [7:0]                       ser_data_o,
    output logic                             ser_valid_o,
    input  logic                             ser_ready_i,
    output logic                             busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
    output logic [CNT_W-1:0]                 byte_cnt_o,
    output logic                             idle_evt_o
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_OCC_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_OCC_W-1:0] c_DEPTH_OCC = c_OCC_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_count;
    logic [c_OCC_W-1:0] r_outstanding;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic               r_idle_evt;

    logic               w_run;
    logic               w_flush;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [c_OCC_W:0]   w_in_use;
    logic               w_credit_ok;
    logic               w_ser_valid;
    logic               w_pop;
    logic               w_req;
    logic               w_ready;
    logic               w_grant;
    logic               w_resp;
    logic               w_push;
    logic               w_fifo_clr;
    logic               w_unused;

    assign w_run        = (r_state == c_ST_RUN);
    assign w_flush      = (r_state == c_ST_FLUSH);
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_DEPTH_OCC);

    // Bytes already buffered plus bytes granted but not yet returned must never
    // exceed the FIFO, so every granted response is guaranteed a slot.
    assign w_in_use    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit_ok = (w_in_use < {1'b0, c_DEPTH_OCC});

    assign w_ser_valid = ~w_fifo_empty & ~w_flush;
    assign w_pop       = w_ser_valid & ser_ready_i;

    assign w_req   = w_run & cfg_en_i & ~cfg_clr_i & w_credit_ok;
    // A full FIFO may still take a byte in the same cycle the head leaves.
    assign w_ready = (w_run & (~w_fifo_full | w_pop)) | w_flush;

    assign w_grant = w_req & data_tx_gnt_i;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign w_resp  = data_tx_valid_i & w_ready & (r_outstanding != '0);
    assign w_push  = w_resp & w_run;

    // Pointers are cleared on the way into FLUSH and held there while flushing.
    assign w_fifo_clr = (w_next_state == c_ST_FLUSH);

    assign data_tx_req_o      = w_req;
    assign data_tx_ready_o    = w_ready;
    assign data_tx_datasize_o = 2'b00;
    assign ser_valid_o        = w_ser_valid;
    assign ser_data_o         = r_mem[r_rd_ptr];
    assign busy_o             = (r_state != c_ST_IDLE);
    assign fifo_count_o       = r_count;
    assign byte_cnt_o         = r_byte_cnt;
    assign idle_evt_o         = r_idle_evt;

    // Only the low byte of a fetched word carries data.
    assign w_unused = ^data_tx_i[31:8];

    // Next-state decode: clear wins, then graceful stop once everything drains.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (cfg_clr_i)     w_next_state = c_ST_FLUSH;
                else if (cfg_en_i) w_next_state = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (cfg_clr_i)
                    w_next_state = c_ST_FLUSH;
                else if (~cfg_en_i && (r_outstanding == '0) && w_fifo_empty)
                    w_next_state = c_ST_IDLE;
            end
            c_ST_FLUSH: begin
                if ((r_outstanding == '0) && ~cfg_clr_i)
                    w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // State register and the one-cycle pulse on returning to IDLE.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= c_ST_IDLE;
            r_idle_evt <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_idle_evt <= (r_state != c_ST_IDLE) && (w_next_state == c_ST_IDLE);
        end
    end

    // Grants issued but not yet answered; grant and response together cancel.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, w_resp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Byte FIFO: storage, pointers and occupancy.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_mem[r_wr_ptr] <= data_tx_i[7:0];
            if (w_fifo_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Bytes handed to the serializer; wraps naturally, cleared only by reset.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i)    r_byte_cnt <= '0;
        else if (w_pop) r_byte_cnt <= r_byte_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_udma_uart_tx_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_uart_tx_fetch_ctrl
// Brief    : Self-checking bench for udma_uart_tx_fetch_ctrl with a uDMA
//            responder, a serializer sink and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_uart_tx_fetch_ctrl;

    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = 4;
    localparam int c_OCC_W = 3;

    logic               sys_clk_i = 1'b0;
    logic               rstn_i    = 1'b1;
    logic               cfg_en_i  = 1'b0;
    logic               cfg_clr_i = 1'b0;
    logic               data_tx_req_o;
    logic               data_tx_gnt_i   = 1'b0;
    logic [1:0]         data_tx_datasize_o;
    logic [31:0]        data_tx_i       = '0;
    logic               data_tx_valid_i = 1'b0;
    logic               data_tx_ready_o;
    logic [7:0]         ser_data_o;
    logic               ser_valid_o;
    logic               ser_ready_i     = 1'b0;
    logic               busy_o;
    logic [c_OCC_W-1:0] fifo_count_o;
    logic [c_CNT_W-1:0] byte_cnt_o;
    logic               idle_evt_o;

    udma_uart_tx_fetch_ctrl #(
        .FIFO_DEPTH (c_DEPTH),
        .CNT_W      (c_CNT_W)
    ) dut (
        .sys_clk_i          (sys_clk_i),
        .rstn_i             (rstn_i),
        .cfg_en_i           (cfg_en_i),
        .cfg_clr_i          (cfg_clr_i),
        .data_tx_req_o      (data_tx_req_o),
        .data_tx_gnt_i      (data_tx_gnt_i),
        .data_tx_datasize_o (data_tx_datasize_o),
        .data_tx_i          (data_tx_i),
        .data_tx_valid_i    (data_tx_valid_i),
        .data_tx_ready_o    (data_tx_ready_o),
        .ser_data_o         (ser_data_o),
        .ser_valid_o        (ser_valid_o),
        .ser_ready_i        (ser_ready_i),
        .busy_o             (busy_o),
        .fifo_count_o       (fifo_count_o),
        .byte_cnt_o         (byte_cnt_o),
        .idle_evt_o         (idle_evt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    int checks = 0;
    int errors = 0;

    // Reference model: abstract mode (0 idle, 1 run, 2 flush), buffered bytes,
    // granted-but-unanswered responses and the count of bytes delivered.
    int         mode;
    logic [7:0] model_q[$];
    resp_t      resp_q[$];
    logic [7:0] popped[$];
    int         exp_cnt;

    // Responder / sink knobs.
    int         delay_plan[$];
    int         dly_min, dly_max;
    int         gnt_pct, ser_pct;
    int         grants_left;
    bit         seq_mode;
    logic [7:0] seq_next;

    int cyc, grant_total, idle_evt_seen, pushpop_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present next-cycle bus inputs from the responder and sink models.
    task automatic drive();
        data_tx_gnt_i = (grants_left != 0) && (int'($urandom_range(99)) < gnt_pct);
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            data_tx_valid_i = 1'b1;
            data_tx_i       = resp_q[0].data;
        end else begin
            data_tx_valid_i = 1'b0;
            data_tx_i       = $urandom;
        end
        ser_ready_i = (int'($urandom_range(99)) < ser_pct);
    endtask

    // One clock: check combinational outputs at negedge, advance the model at
    // the edge, check registered outputs just after it, then drive new inputs.
    task automatic tick();
        logic       s_req, s_rdy, s_sv;
        logic [7:0] s_sd;
        bit         g, r, p, exp_sv, exp_req, exp_rdy;
        int         occ, outst, old_mode, d;
        logic [31:0] rdata;
        @(negedge sys_clk_i);
        s_req = data_tx_req_o;
        s_rdy = data_tx_ready_o;
        s_sv  = ser_valid_o;
        s_sd  = ser_data_o;
        occ   = model_q.size();
        outst = resp_q.size();
        exp_sv  = (occ > 0) && (mode != 2);
        exp_req = (mode == 1) && cfg_en_i && !cfg_clr_i && (occ + outst < c_DEPTH);
        exp_rdy = ((mode == 1) && ((occ < c_DEPTH) || (exp_sv && ser_ready_i))) || (mode == 2);
        chk("ser_valid", s_sv, exp_sv);
        if (exp_sv) chk("ser_data", s_sd, model_q[0]);
        chk("tx_req", s_req, exp_req);
        chk("tx_ready", s_rdy, exp_rdy);
        chk("datasize", data_tx_datasize_o, 0);
        g = s_req && data_tx_gnt_i;
        r = data_tx_valid_i && s_rdy;
        p = s_sv && ser_ready_i;
        rdata = data_tx_i;
        old_mode = mode;
        case (mode)
            0: if (cfg_clr_i) mode = 2; else if (cfg_en_i) mode = 1;
            1: if (cfg_clr_i) mode = 2;
               else if (!cfg_en_i && outst == 0 && occ == 0) mode = 0;
            default: if (outst == 0 && !cfg_clr_i) mode = 0;
        endcase
        @(posedge sys_clk_i);
        #1;
        if (p && model_q.size() > 0) begin
            popped.push_back(model_q.pop_front());
            exp_cnt++;
        end
        if (r && resp_q.size() > 0) begin
            void'(resp_q.pop_front());
            if (old_mode == 1) model_q.push_back(rdata[7:0]);
            if (old_mode == 1 && p) pushpop_cnt++;
        end
        if (g) begin
            d = (delay_plan.size() > 0) ? delay_plan.pop_front()
                                        : int'($urandom_range(dly_max, dly_min));
            resp_q.push_back('{due: cyc + d, data: seq_mode ? {24'h0, seq_next} : $urandom});
            if (seq_mode) seq_next++;
            if (grants_left > 0) grants_left--;
            grant_total++;
        end
        if (mode == 2) model_q.delete();
        cyc++;
        chk("fifo_count", fifo_count_o, model_q.size());
        chk("byte_cnt", byte_cnt_o, exp_cnt % (1 << c_CNT_W));
        chk("busy", busy_o, mode != 0);
        chk("idle_evt", idle_evt_o, (old_mode != 0) && (mode == 0));
        if (idle_evt_o) idle_evt_seen++;
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (mode != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy_o, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},      data_tx_req_o,      0);
        chk({tag, "_ready"},    data_tx_ready_o,    0);
        chk({tag, "_datasize"}, data_tx_datasize_o, 0);
        chk({tag, "_sdata"},    ser_data_o,         0);
        chk({tag, "_svalid"},   ser_valid_o,        0);
        chk({tag, "_busy"},     busy_o,             0);
        chk({tag, "_count"},    fifo_count_o,       0);
        chk({tag, "_bytecnt"},  byte_cnt_o,         0);
        chk({tag, "_idleevt"},  idle_evt_o,         0);
    endtask

    // Assert reset between clock edges and check outputs before the next edge.
    task automatic do_reset(input string tag);
        @(negedge sys_clk_i);
        rstn_i = 1'b0;
        #1;
        check_zero(tag);
        cfg_en_i = 1'b0;
        cfg_clr_i = 1'b0;
        data_tx_gnt_i = 1'b0;
        data_tx_valid_i = 1'b0;
        ser_ready_i = 1'b0;
        model_q.delete();
        resp_q.delete();
        delay_plan.delete();
        mode = 0;
        exp_cnt = 0;
        @(posedge sys_clk_i);
        @(posedge sys_clk_i);
        #1;
        rstn_i = 1'b1;
        drive();
    endtask

    task automatic set_knobs(input int gp, input int dmin, input int dmax,
                             input int sp, input int gl);
        gnt_pct = gp;
        dly_min = dmin;
        dly_max = dmax;
        ser_pct = sp;
        grants_left = gl;
    endtask

    initial begin
        int g0, e0, c0;
        mode = 0; exp_cnt = 0; cyc = 0; grant_total = 0;
        idle_evt_seen = 0; pushpop_cnt = 0;
        seq_mode = 1'b0; seq_next = 8'h00;
        set_knobs(0, 1, 1, 0, 0);

        do_reset("rst0");

        // Basic transfer of three known bytes, then graceful stop.
        seq_mode = 1'b1; seq_next = 8'h41;
        set_knobs(100, 1, 1, 100, 3);
        popped.delete();
        cfg_en_i = 1'b1;
        drive();
        ticks(10);
        e0 = idle_evt_seen;
        cfg_en_i = 1'b0;
        wait_idle("t1_idle", 20);
        ticks(3);
        chk("t1_evt_once", idle_evt_seen - e0, 1);
        chk("t1_byte_cnt", byte_cnt_o, 3);
        chk("t1_npop", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("t1_b0", popped[0], 8'h41);
            chk("t1_b1", popped[1], 8'h42);
            chk("t1_b2", popped[2], 8'h43);
        end
        seq_mode = 1'b0;

        // Backpressure: serializer stalled, immediate grants and responses.
        set_knobs(100, 1, 1, 0, -1);
        cfg_en_i = 1'b1;
        drive();
        g0 = grant_total;
        ticks(15);
        chk("t2_grants", grant_total - g0, 4);
        chk("t2_count", fifo_count_o, 4);
        chk("t2_req_low", data_tx_req_o, 0);
        ser_pct = 100;
        drive();
        tick();
        chk("t2_req_reassert", data_tx_req_o, 1);
        cfg_en_i = 1'b0;
        wait_idle("t2_idle", 40);

        // Outstanding credit: responses delayed by 10 cycles.
        set_knobs(100, 10, 10, 0, -1);
        cfg_en_i = 1'b1;
        drive();
        g0 = grant_total;
        ticks(6);
        chk("t3_grants", grant_total - g0, 4);
        chk("t3_count_empty", fifo_count_o, 0);
        ticks(14);
        chk("t3_count_full", fifo_count_o, 4);
        ser_pct = 100;
        cfg_en_i = 1'b0;
        wait_idle("t3_idle", 60);

        // Flush with two bytes buffered and two responses still in flight.
        set_knobs(100, 1, 1, 0, 4);
        delay_plan = '{1, 1, 25, 25};
        cfg_en_i = 1'b1;
        drive();
        ticks(8);
        chk("t4_count_pre", fifo_count_o, 2);
        c0 = exp_cnt % (1 << c_CNT_W);
        cfg_clr_i = 1'b1;
        cfg_en_i = 1'b0;
        tick();
        cfg_clr_i = 1'b0;
        chk("t4_svalid_off", ser_valid_o, 0);
        wait_idle("t4_idle", 60);
        chk("t4_count_post", fifo_count_o, 0);
        chk("t4_byte_cnt", byte_cnt_o, c0);

        // Streaming: push and pop in the same cycle keep occupancy steady.
        set_knobs(100, 1, 1, 100, -1);
        pushpop_cnt = 0;
        cfg_en_i = 1'b1;
        drive();
        ticks(20);
        chk("t5_pushpop", pushpop_cnt > 0, 1);
        cfg_en_i = 1'b0;
        wait_idle("t5_idle", 40);

        // Randomized traffic with enable toggles and occasional flushes.
        for (int rnd = 0; rnd < 6; rnd++) begin
            set_knobs(int'($urandom_range(100, 30)), 1, int'($urandom_range(8, 1)),
                      int'($urandom_range(100, 20)), -1);
            cfg_en_i = 1'b1;
            drive();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(99) < 5) cfg_en_i = ~cfg_en_i;
                cfg_clr_i = ($urandom_range(99) < 2);
                tick();
            end
            cfg_clr_i = 1'b0;
            cfg_en_i = 1'b0;
            ser_pct = 100;
            wait_idle("rnd_idle", 100);
        end

        // Counter wrap: 17 bytes on a 4-bit counter.
        do_reset("rst1");
        set_knobs(100, 1, 1, 100, 17);
        cfg_en_i = 1'b1;
        drive();
        for (int i = 0; i < 100 && exp_cnt < 17; i++) tick();
        cfg_en_i = 1'b0;
        wait_idle("t6_idle", 40);
        chk("t6_wrap", byte_cnt_o, 1);

        // Reset in the middle of a stream.
        set_knobs(100, 2, 4, 50, -1);
        cfg_en_i = 1'b1;
        drive();
        ticks(9);
        do_reset("rst_mid");
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
